// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the datapath controller and the ALU.
// The master drives the operation; the slave returns the registered result and zero status.
interface alu_if;
   logic [2:0]  alu_op;
   logic [15:0] in1;
   logic [15:0] in2;
   logic [15:0] alu_out;
   logic [15:0] z;

   modport master (output alu_op, in1, in2, input alu_out, z);
   modport slave  (input alu_op, in1, in2, output alu_out, z);
endinterface

// File: rtl/alu.sv
// 16-bit registered ALU: one unsigned operation per clock, one-cycle latency,
// plus a registered zero-status word used by branch control.
module alu (
   input  logic  clock,
   input  logic  reset,
   alu_if.slave  bus
);

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_ADD    = 3'd1,
      OP_SUB    = 3'd2,
      OP_MUL    = 3'd3,
      OP_PASS_A = 3'd4,
      OP_PASS_B = 3'd5,
      OP_INC_A  = 3'd6,
      OP_AND    = 3'd7
   } alu_op_e;

   alu_op_e     op;
   logic [15:0] result;
   logic [15:0] alu_out_q;
   logic [15:0] z_q;

   assign op = alu_op_e'(bus.alu_op);

   // All arithmetic is 16 bits wide, so carries, borrows and the upper
   // product half fall away naturally.
   always_comb begin
      // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
      result = '0;
      unique case (op)
         OP_NOP:    result = '0;
         OP_ADD:    result = bus.in1 + bus.in2;
         OP_SUB:    result = bus.in1 - bus.in2;
         OP_MUL:    result = bus.in1 * bus.in2;
         OP_PASS_A: result = bus.in1;
         OP_PASS_B: result = bus.in2;
         OP_INC_A:  result = bus.in1 + 16'd1;
         OP_AND:    result = bus.in1 & bus.in2;
         default:   result = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (reset) begin
         alu_out_q <= '0;
         z_q       <= '0;
      end else if (op != OP_NOP) begin
         alu_out_q <= result;
         z_q       <= (result == 16'd0) ? 16'd1 : 16'd0;
      end
   end

   assign bus.alu_out = alu_out_q;
   assign bus.z       = z_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU: reset, arithmetic, wrap,
// zero status, NOP hold, reset priority and registered-output behaviour.
module tb_alu;

   localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3,
                          PSA = 3'd4, PSB = 3'd5, INC = 3'd6, AND = 3'd7;

   logic clock;
   logic reset;
   int   vectors;
   int   miscompares;

   alu_if bus ();

   alu dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion before 200000");
      $fatal(1);
   end

   // Drive one operation and move to just after the edge that samples it.
   task automatic step(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      bus.alu_op = op;
      bus.in1    = a;
      bus.in2    = b;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [2:0]  ops  [3] = '{ADD, SUB, MUL};
      logic [15:0] as   [3] = '{16'd4, 16'd3, 16'd7};
      logic [15:0] bs   [3] = '{16'd6, 16'd6, 16'd10};
      logic [15:0] outs [3] = '{16'd10, 16'hFFFD, 16'd70};
      reset = 1'b1;
      step(ADD, 16'd4, 16'd6);
      step(ADD, 16'd4, 16'd6);
      vectors++;
      if (bus.alu_out !== 16'd0 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL reset: got out=%h z=%h, required out=0000 z=0000", bus.alu_out, bus.z);
      end
      reset = 1'b0;
      step(NOP, 16'd9, 16'd9);
      vectors++;
      if (bus.alu_out !== 16'd0 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL nop_after_reset: got out=%h z=%h, required out=0000 z=0000", bus.alu_out, bus.z);
      end
      for (int i = 0; i < 3; i++) begin
         step(ops[i], as[i], bs[i]);
         vectors++;
         if (bus.alu_out !== outs[i] || bus.z !== 16'd0) begin
            miscompares++;
            $display("FAIL stream[%0d]: got out=%h z=%h, required out=%h z=0000", i, bus.alu_out, bus.z, outs[i]);
         end
      end
   endtask

   task automatic test_operand_sweep();
      logic [2:0]  ops  [3] = '{SUB, MUL, ADD};
      logic [15:0] as   [3] = '{16'd102, 16'd253, 16'd255};
      logic [15:0] bs   [3] = '{16'd24, 16'd254, 16'd255};
      logic [15:0] outs [3] = '{16'd78, 16'hFB06, 16'd510};
      for (int i = 0; i < 3; i++) begin
         step(ops[i], as[i], bs[i]);
         vectors++;
         if (bus.alu_out !== outs[i] || bus.z !== 16'd0) begin
            miscompares++;
            $display("FAIL sweep[%0d]: got out=%h z=%h, required out=%h z=0000", i, bus.alu_out, bus.z, outs[i]);
         end
      end
   endtask

   task automatic test_zero_wrap();
      logic [2:0]  ops  [4] = '{SUB, ADD, INC, MUL};
      logic [15:0] as   [4] = '{16'd5, 16'hFFFF, 16'hFFFF, 16'd300};
      logic [15:0] bs   [4] = '{16'd5, 16'd1, 16'd77, 16'd300};
      logic [15:0] outs [4] = '{16'd0, 16'd0, 16'd0, 16'd24464};
      logic [15:0] zs   [4] = '{16'd1, 16'd1, 16'd1, 16'd0};
      for (int i = 0; i < 4; i++) begin
         step(ops[i], as[i], bs[i]);
         vectors++;
         if (bus.alu_out !== outs[i] || bus.z !== zs[i]) begin
            miscompares++;
            $display("FAIL zero_wrap[%0d]: got out=%h z=%h, required out=%h z=%h", i, bus.alu_out, bus.z, outs[i], zs[i]);
         end
      end
   endtask

   task automatic test_hold_pass();
      step(ADD, 16'd1, 16'd2);
      vectors++;
      if (bus.alu_out !== 16'd3 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL add_1_2: got out=%h z=%h, required out=0003 z=0000", bus.alu_out, bus.z);
      end
      for (int i = 0; i < 3; i++) begin
         step(NOP, 16'd9, 16'd9);
         vectors++;
         if (bus.alu_out !== 16'd3 || bus.z !== 16'd0) begin
            miscompares++;
            $display("FAIL nop_hold[%0d]: got out=%h z=%h, required out=0003 z=0000", i, bus.alu_out, bus.z);
         end
      end
      step(PSA, 16'h1234, 16'h5555);
      vectors++;
      if (bus.alu_out !== 16'h1234 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL pass_a: got out=%h z=%h, required out=1234 z=0000", bus.alu_out, bus.z);
      end
      step(PSB, 16'hABCD, 16'd0);
      vectors++;
      if (bus.alu_out !== 16'd0 || bus.z !== 16'd1) begin
         miscompares++;
         $display("FAIL pass_b_zero: got out=%h z=%h, required out=0000 z=0001", bus.alu_out, bus.z);
      end
      step(NOP, 16'h00FF, 16'h0001);
      vectors++;
      if (bus.alu_out !== 16'd0 || bus.z !== 16'd1) begin
         miscompares++;
         $display("FAIL nop_hold_z: got out=%h z=%h, required out=0000 z=0001", bus.alu_out, bus.z);
      end
      step(AND, 16'hF0F0, 16'h0FF0);
      vectors++;
      if (bus.alu_out !== 16'h00F0 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL and: got out=%h z=%h, required out=00f0 z=0000", bus.alu_out, bus.z);
      end
   endtask

   task automatic test_reset_priority();
      reset = 1'b1;
      step(ADD, 16'd7, 16'd8);
      vectors++;
      if (bus.alu_out !== 16'd0 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_priority: got out=%h z=%h, required out=0000 z=0000", bus.alu_out, bus.z);
      end
      reset = 1'b0;
      step(ADD, 16'd7, 16'd8);
      vectors++;
      if (bus.alu_out !== 16'd15 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL after_reset_pulse: got out=%h z=%h, required out=000f z=0000", bus.alu_out, bus.z);
      end
   endtask

   task automatic test_registered_output();
      step(ADD, 16'd1, 16'd0);
      vectors++;
      if (bus.alu_out !== 16'd1 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL reg_first: got out=%h z=%h, required out=0001 z=0000", bus.alu_out, bus.z);
      end
      bus.in1 = 16'd100;
      #3;
      vectors++;
      if (bus.alu_out !== 16'd1 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL reg_midcycle: got out=%h z=%h, required out=0001 z=0000", bus.alu_out, bus.z);
      end
      bus.in1 = 16'd0;
      #3;
      vectors++;
      if (bus.alu_out !== 16'd1 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL reg_midcycle_zero: got out=%h z=%h, required out=0001 z=0000", bus.alu_out, bus.z);
      end
      step(ADD, 16'd100, 16'd0);
      vectors++;
      if (bus.alu_out !== 16'd100 || bus.z !== 16'd0) begin
         miscompares++;
         $display("FAIL reg_next_edge: got out=%h z=%h, required out=0064 z=0000", bus.alu_out, bus.z);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      bus.alu_op  = NOP;
      bus.in1     = '0;
      bus.in2     = '0;
      test_reset();
      test_operand_sweep();
      test_zero_wrap();
      test_hold_pass();
      test_reset_priority();
      test_registered_output();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
